// File: rtl/rvc_compress_packer.sv
`default_nettype none
// ============================================================================
// Module   : rvc_compress_packer
// Purpose  : Rewrites a subset of RV32I instructions into 16-bit RVC parcels
//            and packs 16/32-bit parcels little-endian into a 32-bit stream.
// Revision : 1.0 - initial release
// ============================================================================
module rvc_compress_packer #(
  parameter int          ENABLE_RVC = 1,
  parameter logic [15:0] PAD_HW     = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        empty,
  output logic [15:0] comp_count
);

  logic        r_pend_valid;
  logic [15:0] r_pend_hw;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [15:0] r_comp_count;

  // Instruction field decode
  logic [6:0]  w_op;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_f7;
  logic [11:0] w_i_imm;
  logic [20:0] w_j_off;
  logic [12:0] w_b_off;
  logic        w_i_small;
  logic        w_j_small;
  logic        w_b_small;
  logic        w_is_addi;
  logic        w_is_add;
  logic        w_is_jal;
  logic        w_is_bz;

  assign w_op    = in_instr[6:0];
  assign w_rd    = in_instr[11:7];
  assign w_f3    = in_instr[14:12];
  assign w_rs1   = in_instr[19:15];
  assign w_rs2   = in_instr[24:20];
  assign w_f7    = in_instr[31:25];
  assign w_i_imm = in_instr[31:20];
  assign w_j_off = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign w_b_off = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

  // A sign-extended value fits the narrow field when all bits above it match its sign
  assign w_i_small = (w_i_imm[11:5] == {7{w_i_imm[5]}});
  assign w_j_small = (w_j_off[20:11] == {10{w_j_off[11]}});
  assign w_b_small = (w_b_off[12:8] == {5{w_b_off[8]}});

  assign w_is_addi = (w_op == 7'h13) && (w_f3 == 3'b000) && (w_rd != 5'd0);
  assign w_is_add  = (w_op == 7'h33) && (w_f3 == 3'b000) && (w_f7 == 7'd0) &&
                     (w_rd != 5'd0) && (w_rs2 != 5'd0);
  assign w_is_jal  = (w_op == 7'h6F) && (w_rd == 5'd0);
  assign w_is_bz   = (w_op == 7'h63) && (w_f3[2:1] == 2'b00) && (w_rs2 == 5'd0) &&
                     (w_rs1[4:3] == 2'b01);

  logic        w_is_c;
  logic [15:0] w_parcel;

  // Compression rule table, first match wins
  always_comb begin
    w_is_c   = 1'b0;
    w_parcel = 16'h0000;
    if (ENABLE_RVC != 0) begin
      if (w_is_addi && (w_rs1 == w_rd) && (w_i_imm != 12'd0) && w_i_small) begin
        w_is_c   = 1'b1;
        w_parcel = {3'b000, w_i_imm[5], w_rd, w_i_imm[4:0], 2'b01};
      end else if (w_is_addi && (w_rs1 == 5'd0) && w_i_small) begin
        w_is_c   = 1'b1;
        w_parcel = {3'b010, w_i_imm[5], w_rd, w_i_imm[4:0], 2'b01};
      end else if (w_is_add && (w_rs1 == 5'd0)) begin
        w_is_c   = 1'b1;
        w_parcel = {4'b1000, w_rd, w_rs2, 2'b10};
      end else if (w_is_add && (w_rs1 == w_rd)) begin
        w_is_c   = 1'b1;
        w_parcel = {4'b1001, w_rd, w_rs2, 2'b10};
      end else if (w_is_jal && w_j_small) begin
        w_is_c   = 1'b1;
        w_parcel = {3'b101, w_j_off[11], w_j_off[4], w_j_off[9:8], w_j_off[10],
                    w_j_off[6], w_j_off[7], w_j_off[3:1], w_j_off[5], 2'b01};
      end else if (w_is_bz && w_b_small) begin
        w_is_c   = 1'b1;
        w_parcel = {2'b11, w_f3[0], w_b_off[8], w_b_off[4:3], w_rs1[2:0],
                    w_b_off[7:6], w_b_off[2:1], w_b_off[5], 2'b01};
      end
    end
  end

  logic        w_accept;
  logic        w_flush_go;
  logic        w_load;
  logic [31:0] w_word;
  logic        w_pend_valid_nxt;
  logic [15:0] w_pend_hw_nxt;

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & in_ready;
  // A flush yields to a simultaneous instruction and only fires when there is a halfword to pad
  assign w_flush_go = flush & ~in_valid & in_ready & r_pend_valid;

  // Parcel packing: combine the new parcel with any pending halfword
  always_comb begin
    w_load           = 1'b0;
    w_word           = 32'h0;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_hw_nxt    = r_pend_hw;
    if (w_accept) begin
      if (!r_pend_valid) begin
        if (w_is_c) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_hw_nxt    = w_parcel;
        end else begin
          w_load = 1'b1;
          w_word = in_instr;
        end
      end else begin
        w_load = 1'b1;
        if (w_is_c) begin
          w_word           = {w_parcel, r_pend_hw};
          w_pend_valid_nxt = 1'b0;
        end else begin
          w_word        = {in_instr[15:0], r_pend_hw};
          w_pend_hw_nxt = in_instr[31:16];
        end
      end
    end else if (w_flush_go) begin
      w_load           = 1'b1;
      w_word           = {PAD_HW, r_pend_hw};
      w_pend_valid_nxt = 1'b0;
    end
  end

  // State registers: pending halfword, output register and compression counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_hw    <= 16'h0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 32'h0;
      r_comp_count <= 16'h0;
    end else begin
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_hw    <= w_pend_hw_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && w_is_c) begin
        r_comp_count <= r_comp_count + 16'd1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign empty      = ~r_pend_valid & ~r_out_valid;
  assign comp_count = r_comp_count;

endmodule
`default_nettype wire

// File: tb/tb_rvc_compress_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvc_compress_packer
// Purpose  : Self-checking bench with directed cases and random traffic
//            against a halfword-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvc_compress_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, empty;
  logic [31:0] out_data;
  logic [15:0] comp_count;
  logic        nc_in_ready, nc_out_valid, nc_empty;
  logic [31:0] nc_out_data;
  logic [15:0] nc_comp_count;

  rvc_compress_packer #(.ENABLE_RVC(1), .PAD_HW(16'h0001)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .empty(empty),
    .comp_count(comp_count)
  );

  rvc_compress_packer #(.ENABLE_RVC(0), .PAD_HW(16'h0001)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(nc_out_valid),
    .out_ready(out_ready), .out_data(nc_out_data), .empty(nc_empty),
    .comp_count(nc_comp_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] hq[$];      // halfwords not yet forming a word
  logic [31:0] eq[$];      // words produced, waiting to be consumed
  logic [15:0] m_cc = 16'h0;
  logic [31:0] last_word = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference compressor: decodes fields into integers and applies the rule list
  function automatic logic [16:0] ref_compress(input logic [31:0] x);
    int op, rd, f3, rs1, rs2, f7, imm, off;
    logic signed [11:0] si;
    logic signed [20:0] sj;
    logic signed [12:0] sb;
    logic [31:0] u;
    op = int'(x[6:0]); rd = int'(x[11:7]); f3 = int'(x[14:12]);
    rs1 = int'(x[19:15]); rs2 = int'(x[24:20]); f7 = int'(x[31:25]);
    si = x[31:20]; imm = si; u = imm;
    if (op == 'h13 && f3 == 0 && rd != 0 && rs1 == rd && imm != 0 && imm >= -32 && imm <= 31)
      return {1'b1, 3'b000, u[5], 5'(rd), u[4:0], 2'b01};
    if (op == 'h13 && f3 == 0 && rd != 0 && rs1 == 0 && imm >= -32 && imm <= 31)
      return {1'b1, 3'b010, u[5], 5'(rd), u[4:0], 2'b01};
    if (op == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && rs1 == 0)
      return {1'b1, 4'b1000, 5'(rd), 5'(rs2), 2'b10};
    if (op == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && rs1 == rd)
      return {1'b1, 4'b1001, 5'(rd), 5'(rs2), 2'b10};
    sj = {x[31], x[19:12], x[20], x[30:21], 1'b0}; off = sj; u = off;
    if (op == 'h6F && rd == 0 && off >= -2048 && off <= 2046)
      return {1'b1, 3'b101, u[11], u[4], u[9:8], u[10], u[6], u[7], u[3:1], u[5], 2'b01};
    sb = {x[31], x[7], x[30:25], x[11:8], 1'b0}; off = sb; u = off;
    if (op == 'h63 && (f3 == 0 || f3 == 1) && rs2 == 0 && rs1 >= 8 && rs1 <= 15 &&
        off >= -256 && off <= 254)
      return {1'b1, (f3 == 0) ? 3'b110 : 3'b111, u[8], u[4:3], 3'(rs1), u[7:6], u[2:1], u[5], 2'b01};
    return 17'h0;
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int rd);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_j(input int off, input int rd);
    logic [20:0] o;
    o = 21'(off);
    return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1, input int f3);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'h63};
  endfunction

  task automatic m_pack();
    logic [15:0] lo, hi;
    while (hq.size() >= 2) begin
      lo = hq.pop_front();
      hi = hq.pop_front();
      eq.push_back({hi, lo});
    end
  endtask

  // One clock of stimulus: drive after negedge, check and update model, then pass the posedge
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
    logic [16:0] r;
    @(negedge clk);
    in_valid = v; in_instr = ins; flush = fl; out_ready = rdy;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (eq.size() == 0) || rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, eq.size() != 0});
    chk("empty", {31'd0, empty}, {31'd0, (eq.size() == 0) && (hq.size() == 0)});
    chk("comp_count", {16'd0, comp_count}, {16'd0, m_cc});
    if (out_valid && out_ready && eq.size() != 0) begin
      last_word = out_data;
      chk("out_data", out_data, eq.pop_front());
    end
    if (v && in_ready) begin
      r = ref_compress(ins);
      if (r[16]) begin
        hq.push_back(r[15:0]);
        m_cc++;
      end else begin
        hq.push_back(ins[15:0]);
        hq.push_back(ins[31:16]);
      end
      m_pack();
    end else if (fl && !v && in_ready && hq.size() == 1) begin
      hq.push_back(16'h0001);
      m_pack();
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = 32'h0;
    hq.delete(); eq.delete(); m_cc = 16'h0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_comp_count", {16'd0, comp_count}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] hold;
    logic [31:0] ins;
    int k, a, b, c;

    // addi x8,x8,1 twice packs into one word
    do_reset();
    step(1'b1, 32'h00140413, 1'b0, 1'b1);
    step(1'b1, 32'h00140413, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("addi_pair_word", last_word, 32'h04050405);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("addi_pair_cc", {16'd0, comp_count}, 32'd2);
    chk("addi_pair_empty", {31'd0, empty}, 32'd1);

    // c.mv then a 32-bit addi, then flush the leftover upper half
    do_reset();
    step(1'b1, 32'h00B00533, 1'b0, 1'b1);
    step(1'b1, 32'h06430293, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("mv_addi_word", last_word, 32'h0293852E);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("flush_word", last_word, 32'h00010643);
    chk("mv_addi_cc", {16'd0, comp_count}, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // c.j pair, then an out-of-range jump passes through
    do_reset();
    step(1'b1, 32'h00C0006F, 1'b0, 1'b1);
    step(1'b1, 32'h00C0006F, 1'b0, 1'b1);
    step(1'b1, enc_j(2048, 0), 1'b0, 1'b1);
    chk("cj_pair_word", last_word, 32'hA031A031);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("jal_far_word", last_word, 32'h0010006F);

    // c.beqz and the two branch forms that must not compress
    do_reset();
    step(1'b1, enc_b(42, 0, 8, 0), 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, enc_b(42, 0, 16, 0), 1'b0, 1'b1);
    chk("beqz_word", last_word, 32'h0001C40D);
    step(1'b1, enc_b(256, 0, 8, 0), 1'b0, 1'b1);
    chk("beq_x16_word", last_word, enc_b(42, 0, 16, 0));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("beq_far_word", last_word, enc_b(256, 0, 8, 0));

    // Backpressure holds data and blocks input; release consumes and accepts together
    do_reset();
    step(1'b1, 32'h00140413, 1'b0, 1'b1);
    step(1'b1, 32'h00140413, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    hold = out_data;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h00C0006F, 1'b0, 1'b0);
      chk("bp_stable", out_data, hold);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    step(1'b1, 32'h00C0006F, 1'b0, 1'b1);
    chk("bp_release_word", last_word, 32'h04050405);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset with a halfword pending
    do_reset();
    step(1'b1, 32'h00140413, 1'b0, 1'b1);
    #1;
    chk("pre_rst_empty", {31'd0, empty}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_empty", {31'd0, empty}, 32'd1);
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_comp_count", {16'd0, comp_count}, 32'd0);
    hq.delete(); eq.delete(); m_cc = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Compression disabled: the same addi passes through whole
    do_reset();
    step(1'b1, 32'h00140413, 1'b0, 1'b1);
    #1;
    chk("nc_out_valid", {31'd0, nc_out_valid}, 32'd1);
    chk("nc_out_data", nc_out_data, 32'h00140413);
    chk("nc_comp_count", {16'd0, nc_comp_count}, 32'd0);
    chk("nc_empty", {31'd0, nc_empty}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic biased toward the compressible forms
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      k = int'($urandom_range(0, 7));
      a = int'($urandom_range(0, 31));
      b = int'($urandom_range(0, 31));
      c = int'($urandom_range(0, 80)) - 40;
      case (k)
        0: ins = enc_i(c, a, a);
        1: ins = enc_i(c, 0, a);
        2: ins = enc_r(0, b, ($urandom_range(0, 1) != 0) ? a : 0, a);
        3: ins = enc_r(($urandom_range(0, 3) == 0) ? 32 : 0, b, int'($urandom_range(0, 31)), a);
        4: ins = enc_j(2 * (int'($urandom_range(0, 2200)) - 1100), ($urandom_range(0, 3) == 0) ? a : 0);
        5: ins = enc_b(2 * (int'($urandom_range(0, 300)) - 150),
                       ($urandom_range(0, 4) == 0) ? b : 0,
                       int'($urandom_range(6, 17)), int'($urandom_range(0, 2)));
        6: ins = $urandom;
        default: ins = enc_i(c, int'($urandom_range(0, 31)), a);
      endcase
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("final_empty", {31'd0, empty}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
